// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types, default sizes and a ring rotate helper for the round-robin arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rr_ring_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;
    localparam int ROT_W        = 64;

    // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
    function automatic logic [ROT_W-1:0] rotl1(input logic [ROT_W-1:0] v, input int n);
        logic [ROT_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_W - 1; i++) begin
            if (i < n - 1) r[i+1] = v[i];
        end
        r[0] = v[6'(n - 1)];
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Wrap-around priority pick: first set req bit scanning upward from the one-hot ptr.
// Latency: combinational.
// Backpressure: none; found is low when req is all-zero.
module rr_pick_onehot #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           found
);

    always_comb begin
        int base;
        int idx;
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        base    = 0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) base = i;
        end
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[IDW'(idx)]) begin
                found              = 1'b1;
                pick[IDW'(idx)]    = 1'b1;
                pick_id            = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with one-hot ring pointer; optional hold timeout via RR_RING_ARBITER_TIMEOUT_EN.
// Latency: req sampled in IDLE -> gnt registered at the same edge; one RELEASE cycle after each grant.
// Backpressure: grant held while grantee keeps req high; en low blocks only new grants.
module rr_ring_arbiter
    import rr_ring_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic [N-1:0]         ptr,
    output logic                 preempt
);

    localparam int IDW = $clog2(N);

    state_t           state, state_n;
    logic [N-1:0]     gnt_n, ptr_n, pick;
    logic [IDW-1:0]   gnt_id_n, pick_id;
    logic             found, preempt_n;
    logic [ROT_W-1:0] rot_full;

    rr_pick_onehot #(.N(N), .IDW(IDW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .found   (found)
    );

`ifdef RR_RING_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_expired;

    // Counts cycles already spent in GRANT; expiry releases at the edge ending cycle MAX_HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n)              hold_cnt <= '0;
        else if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
        else                     hold_cnt <= '0;
    end

    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    logic hold_expired;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        ptr_n     = ptr;
        preempt_n = 1'b0;
        rot_full  = '0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_n  = GRANT;
                    gnt_n    = pick;
                    gnt_id_n = pick_id;
                    rot_full = rotl1(ROT_W'(pick), N);
                    ptr_n    = rot_full[N-1:0];
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_n  = RELEASE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                end else if (hold_expired) begin
                    state_n   = RELEASE;
                    gnt_n     = '0;
                    gnt_id_n  = '0;
                    preempt_n = 1'b1;
                end
            end
            RELEASE: state_n = IDLE;
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            ptr     <= N'(1);
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            ptr     <= ptr_n;
            preempt <= preempt_n;
        end
    end

    assign busy = |gnt;

endmodule
